// File: rtl/i2c_seq_pkg.sv
// Shared types for the single-byte I2C master sequencer.
// Transaction states, bit-slot quarters and field widths.
package i2c_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    DATA,
    DACK,
    STOP
  } state_t;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } quarter_t;

  localparam int ADDR_BITS = 7;
  localparam int DATA_BITS = 8;

endpackage

// File: rtl/i2c_master_seq_if.sv
// Requester handshake plus open-drain pad bundle for i2c_master_seq.
// master = sequencer side, slave = requesters/pads side.
interface i2c_master_seq_if
  import i2c_seq_pkg::*;
#(
  parameter int NREQ = 4
);

  logic [NREQ-1:0]           req;
  logic [NREQ*ADDR_BITS-1:0] req_addr;
  logic [NREQ-1:0]           req_rw;
  logic [NREQ*DATA_BITS-1:0] req_wdata;
  logic [NREQ-1:0]           gnt;
  logic                      busy;
  logic                      done;
  logic                      ack_err;
  logic [DATA_BITS-1:0]      rdata;
  logic                      scl_o;
  logic                      sda_o;
  logic                      scl_i;
  logic                      sda_i;

  modport master (
    input  req, req_addr, req_rw, req_wdata,
    input  scl_i, sda_i,
    output gnt, busy, done, ack_err, rdata,
    output scl_o, sda_o
  );

  modport slave (
    output req, req_addr, req_rw, req_wdata,
    output scl_i, sda_i,
    input  gnt, busy, done, ack_err, rdata,
    input  scl_o, sda_o
  );

endinterface

// File: rtl/i2c_quarter_gen.sv
// SCL quarter-period timer: counts 0..DIVIDER-1 per quarter,
// freezes while the slave stretches SCL, held at zero by clear.
module i2c_quarter_gen
  import i2c_seq_pkg::*;
#(
  parameter int DIVIDER = 7000,
  parameter int CBITS   = 15
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     stall,
  input  logic     clear,
  output quarter_t quarter,
  output logic     qend
);

  localparam logic [CBITS-1:0] LAST = CBITS'(DIVIDER - 1);

  logic [CBITS-1:0] cnt_q;
  quarter_t         q_q;

  assign qend    = !stall && (cnt_q == LAST);
  assign quarter = q_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
      q_q   <= Q0;
    end else if (qend) begin
      cnt_q <= '0;
      q_q   <= quarter_t'(q_q + 2'd1);
    end else if (!stall) begin
      cnt_q <= cnt_q + CBITS'(1);
    end
  end

endmodule

// File: rtl/i2c_master_seq.sv
// Round-robin arbitrated single-byte I2C master: START, address,
// ACK, data, ACK, STOP on open-drain SCL/SDA with clock stretching.
module i2c_master_seq
  import i2c_seq_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DIVIDER = 7000,
  parameter int CBITS   = 15
) (
  input logic clk,
  input logic rst,
  i2c_master_seq_if.master bus
);

  localparam int PW = $clog2(NREQ);

  state_t               state_q, state_d;
  logic [2:0]           bit_q, bit_d;
  logic [PW-1:0]        ptr_q, sel;
  logic                 found;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 rw_q;
  logic [DATA_BITS-1:0] wdata_q, shift_q, rdata_q;
  logic                 ack_err_q, samp_q, done_q;
  logic [NREQ-1:0]      gnt_q;
  quarter_t             quarter;
  logic                 qend, slot_end, sample;
  logic                 scl, sda, hi, stall;
  logic [7:0]           abyte;

  logic [ADDR_BITS-1:0] addr_arr [NREQ];
  logic [DATA_BITS-1:0] wd_arr   [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_BITS +: ADDR_BITS];
    assign wd_arr[g]   = bus.req_wdata[g*DATA_BITS +: DATA_BITS];
  end

  i2c_quarter_gen #(
    .DIVIDER(DIVIDER),
    .CBITS  (CBITS)
  ) u_qgen (
    .clk    (clk),
    .rst    (rst),
    .stall  (stall),
    .clear  (state_q == IDLE),
    .quarter(quarter),
    .qend   (qend)
  );

  assign slot_end = qend && (quarter == Q3);
  assign sample   = qend && (quarter == Q2);
  assign hi       = (quarter == Q2) || (quarter == Q3);
  assign stall    = scl && !bus.scl_i;
  assign abyte    = {addr_q, rw_q};

  // First pending request at or after the pointer, wrapping.
  always_comb begin
    int            j;
    logic [PW-1:0] jj;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      jj = PW'(j);
      if (!found && bus.req[jj]) begin
        found = 1'b1;
        sel   = jj;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    unique case (state_q)
      IDLE:  if (found) state_d = START;
      START: if (slot_end) begin
        state_d = ADDR;
        bit_d   = '0;
      end
      ADDR:  if (slot_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = AACK;
      end
      AACK:  if (slot_end) state_d = samp_q ? STOP : DATA;
      DATA:  if (slot_end) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = DACK;
      end
      DACK:  if (slot_end) state_d = STOP;
      STOP:  if (slot_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    scl = 1'b1;
    sda = 1'b1;
    unique case (state_q)
      IDLE:  ;
      START: sda = !hi;
      ADDR: begin
        scl = hi;
        sda = abyte[~bit_q];
      end
      DATA: begin
        scl = hi;
        sda = rw_q | wdata_q[~bit_q];
      end
      AACK, DACK: scl = hi;
      STOP: begin
        scl = hi;
        sda = (quarter == Q3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_q     <= '0;
      ptr_q     <= '0;
      addr_q    <= '0;
      rw_q      <= 1'b0;
      wdata_q   <= '0;
      shift_q   <= '0;
      rdata_q   <= '0;
      ack_err_q <= 1'b0;
      samp_q    <= 1'b0;
      done_q    <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      gnt_q   <= '0;
      done_q  <= 1'b0;
      if (state_q == IDLE && found) begin
        gnt_q     <= NREQ'(1) << sel;
        ptr_q     <= (int'(sel) == NREQ - 1) ? '0 : sel + PW'(1);
        addr_q    <= addr_arr[sel];
        rw_q      <= bus.req_rw[sel];
        wdata_q   <= wd_arr[sel];
        ack_err_q <= 1'b0;
      end
      if (sample) begin
        samp_q <= bus.sda_i;
        if (state_q == AACK && bus.sda_i) ack_err_q <= 1'b1;
        if (state_q == DACK && !rw_q && bus.sda_i) ack_err_q <= 1'b1;
        if (state_q == DATA) shift_q <= {shift_q[DATA_BITS-2:0], bus.sda_i};
      end
      if (slot_end && state_q == DACK && rw_q) rdata_q <= shift_q;
      if (slot_end && state_q == STOP) done_q <= 1'b1;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = done_q;
  assign bus.ack_err = ack_err_q;
  assign bus.rdata   = rdata_q;
  assign bus.scl_o   = scl;
  assign bus.sda_o   = sda;

endmodule

// File: tb/tb_i2c_master_seq.sv
// Directed bench for i2c_master_seq with a bit-counting I2C slave model.
module tb_i2c_master_seq;

  localparam int NREQ = 4;
  localparam int DIV  = 4;
  localparam int CB   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_seq_if #(.NREQ(NREQ)) ifc ();

  i2c_master_seq #(
    .NREQ   (NREQ),
    .DIVIDER(DIV),
    .CBITS  (CB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  int checks = 0;
  int passes = 0;

  logic       nack_addr = 1'b0;
  logic       nack_data = 1'b0;
  logic       rd_mode   = 1'b0;
  logic       stretch_arm = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  int   bcnt = 0;
  logic scl_d = 1'b1;
  logic armed_low = 1'b0;
  int   left = 10;
  logic bitv [32];
  logic slave_sda, stretch;
  int   idx;

  // Slave drives bit idx: the one whose SCL rise is current or next.
  always_comb begin
    idx = (ifc.scl_i && scl_d) ? bcnt : bcnt + 1;
    slave_sda = 1'b1;
    if (idx == 9) slave_sda = nack_addr;
    else if (rd_mode && idx >= 10 && idx <= 17) slave_sda = rd_byte[3'(17 - idx)];
    else if (!rd_mode && idx == 18) slave_sda = nack_data;
  end

  assign stretch   = armed_low && (left != 0);
  assign ifc.scl_i = ifc.scl_o & ~stretch;
  assign ifc.sda_i = ifc.sda_o & slave_sda;

  always @(negedge clk) begin
    if (ifc.gnt != '0) bcnt <= 0;
    else if (ifc.scl_i && !scl_d) begin
      bitv[bcnt[4:0]] <= ifc.sda_i;
      bcnt <= bcnt + 1;
    end
    scl_d <= ifc.scl_i;
    if (!stretch_arm) armed_low <= 1'b0;
    else if (bcnt == 2 && !ifc.scl_o) armed_low <= 1'b1;
  end

  always @(posedge clk) begin
    if (!stretch_arm) left <= 10;
    else if (ifc.scl_o && !ifc.scl_i && left != 0) left <= left - 1;
  end

  function automatic logic [7:0] grab(input int base);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[7-k] = bitv[5'(base + k)];
    return r;
  endfunction

  task automatic set_slot(input int i, input logic [6:0] a,
                          input logic rw, input logic [7:0] wd);
    ifc.req_addr[i*7 +: 7]  = a;
    ifc.req_rw[i]           = rw;
    ifc.req_wdata[i*8 +: 8] = wd;
  endtask

  task automatic wait_gnt(output logic [3:0] g);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifc.gnt == '0 && n < 500);
    g = ifc.gnt;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!ifc.done && lat < 2000) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic run_req(input int i, input logic [6:0] a, input logic rw,
                         input logic [7:0] wd, output logic [3:0] g,
                         output int lat);
    @(negedge clk);
    set_slot(i, a, rw, wd);
    ifc.req[i] = 1'b1;
    wait_gnt(g);
    ifc.req[i] = 1'b0;
    wait_done(lat);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (ifc.scl_o !== 1'b1) $display("FAIL rst_scl: got %b want 1", ifc.scl_o); else passes++;
    checks++; if (ifc.sda_o !== 1'b1) $display("FAIL rst_sda: got %b want 1", ifc.sda_o); else passes++;
    checks++; if (ifc.gnt !== 4'b0) $display("FAIL rst_gnt: got %b want 0000", ifc.gnt); else passes++;
    checks++; if (ifc.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", ifc.busy); else passes++;
    checks++; if (ifc.done !== 1'b0) $display("FAIL rst_done: got %b want 0", ifc.done); else passes++;
    checks++; if (ifc.ack_err !== 1'b0) $display("FAIL rst_ack_err: got %b want 0", ifc.ack_err); else passes++;
    checks++; if (ifc.rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", ifc.rdata); else passes++;
    rst = 1'b0;
  endtask

  task automatic test_write();
    logic [3:0] g;
    int lat;
    nack_addr = 1'b0; nack_data = 1'b0; rd_mode = 1'b0;
    run_req(0, 7'h50, 1'b0, 8'hA5, g, lat);
    checks++; if (g !== 4'b0001) $display("FAIL wr_gnt: got %b want 0001", g); else passes++;
    checks++; if (lat !== 320) $display("FAIL wr_latency: got %0d want 320", lat); else passes++;
    checks++; if (ifc.busy !== 1'b0) $display("FAIL wr_busy_at_done: got %b want 0", ifc.busy); else passes++;
    checks++; if (ifc.ack_err !== 1'b0) $display("FAIL wr_ack_err: got %b want 0", ifc.ack_err); else passes++;
    checks++; if (grab(0) !== 8'hA0) $display("FAIL wr_addr_bits: got %h want a0", grab(0)); else passes++;
    checks++; if (grab(9) !== 8'hA5) $display("FAIL wr_data_bits: got %h want a5", grab(9)); else passes++;
    @(negedge clk);
    checks++; if (ifc.done !== 1'b0) $display("FAIL wr_done_pulse: got %b want 0", ifc.done); else passes++;
  endtask

  task automatic test_nack();
    logic [3:0] g;
    int lat;
    nack_addr = 1'b1;
    run_req(0, 7'h50, 1'b0, 8'hA5, g, lat);
    checks++; if (lat !== 176) $display("FAIL nack_latency: got %0d want 176", lat); else passes++;
    checks++; if (ifc.ack_err !== 1'b1) $display("FAIL nack_ack_err: got %b want 1", ifc.ack_err); else passes++;
    checks++; if (bcnt !== 10) $display("FAIL nack_scl_pulses: got %0d want 10", bcnt); else passes++;
    repeat (5) @(negedge clk);
    checks++; if (ifc.ack_err !== 1'b1) $display("FAIL nack_ack_err_hold: got %b want 1", ifc.ack_err); else passes++;
    nack_addr = 1'b0;
  endtask

  task automatic test_read();
    logic [3:0] g;
    int lat;
    rd_mode = 1'b1; rd_byte = 8'h3C;
    run_req(3, 7'h21, 1'b1, 8'h00, g, lat);
    checks++; if (g !== 4'b1000) $display("FAIL rd_gnt: got %b want 1000", g); else passes++;
    checks++; if (lat !== 320) $display("FAIL rd_latency: got %0d want 320", lat); else passes++;
    checks++; if (ifc.rdata !== 8'h3C) $display("FAIL rd_rdata: got %h want 3c", ifc.rdata); else passes++;
    checks++; if (ifc.ack_err !== 1'b0) $display("FAIL rd_ack_err: got %b want 0", ifc.ack_err); else passes++;
    checks++; if (grab(0) !== 8'h43) $display("FAIL rd_addr_bits: got %h want 43", grab(0)); else passes++;
    checks++; if (bitv[17] !== 1'b1) $display("FAIL rd_master_nack: got %b want 1", bitv[17]); else passes++;
    rd_mode = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [3:0] g;
    logic [3:0] exp_g [4];
    int lat;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010;
    exp_g[2] = 4'b1000; exp_g[3] = 4'b0001;
    @(negedge clk);
    set_slot(0, 7'h10, 1'b0, 8'h01);
    set_slot(1, 7'h11, 1'b0, 8'h02);
    set_slot(3, 7'h13, 1'b0, 8'h08);
    ifc.req = 4'b1011;
    for (int n = 0; n < 4; n++) begin
      wait_gnt(g);
      checks++; if (g !== exp_g[n]) $display("FAIL rr_gnt%0d: got %b want %b", n, g, exp_g[n]); else passes++;
    end
    ifc.req = 4'b0000;
    wait_done(lat);
    checks++; if (lat !== 320) $display("FAIL rr_last_latency: got %0d want 320", lat); else passes++;
    checks++; if (ifc.rdata !== 8'h3C) $display("FAIL rr_rdata_hold: got %h want 3c", ifc.rdata); else passes++;
  endtask

  task automatic test_stretch();
    logic [3:0] g;
    int lat;
    stretch_arm = 1'b1;
    run_req(0, 7'h50, 1'b0, 8'hA5, g, lat);
    checks++; if (lat !== 330) $display("FAIL stretch_latency: got %0d want 330", lat); else passes++;
    checks++; if (grab(9) !== 8'hA5) $display("FAIL stretch_data_bits: got %h want a5", grab(9)); else passes++;
    stretch_arm = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [3:0] g;
    int lat;
    int seen = 0;
    @(negedge clk);
    set_slot(1, 7'h11, 1'b0, 8'h5A);
    ifc.req[1] = 1'b1;
    wait_gnt(g);
    ifc.req[1] = 1'b0;
    checks++; if (g !== 4'b0010) $display("FAIL mid_gnt: got %b want 0010", g); else passes++;
    repeat (228) @(negedge clk);
    checks++; if (ifc.busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", ifc.busy); else passes++;
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({ifc.scl_o, ifc.sda_o} !== 2'b11) $display("FAIL mid_lines: got %b want 11", {ifc.scl_o, ifc.sda_o}); else passes++;
    checks++; if (ifc.busy !== 1'b0) $display("FAIL mid_busy_after: got %b want 0", ifc.busy); else passes++;
    checks++; if (ifc.rdata !== 8'h00) $display("FAIL mid_rdata: got %h want 00", ifc.rdata); else passes++;
    if (ifc.done) seen++;
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ifc.done) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL mid_no_done: got %0d pulses want 0", seen); else passes++;
    set_slot(0, 7'h22, 1'b0, 8'h33);
    set_slot(3, 7'h23, 1'b0, 8'h44);
    ifc.req = 4'b1001;
    wait_gnt(g);
    ifc.req = 4'b0000;
    checks++; if (g !== 4'b0001) $display("FAIL mid_next_gnt: got %b want 0001", g); else passes++;
    wait_done(lat);
    checks++; if (lat !== 320) $display("FAIL mid_next_latency: got %0d want 320", lat); else passes++;
  endtask

  initial begin
    ifc.req       = '0;
    ifc.req_addr  = '0;
    ifc.req_rw    = '0;
    ifc.req_wdata = '0;
    test_reset();
    test_write();
    test_nack();
    test_read();
    test_round_robin();
    test_stretch();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Single-byte I2C master transaction sequencer shared by NREQ requesters. It round-robin arbitrates pending requests, then generates the full START / address / ACK / data / ACK / STOP sequence on open-drain SCL/SDA. Bit timing comes from a quarter-period divider and honours slave clock stretching. It sits between on-chip requesters and the board I2C pads.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..8)
- DIVIDER, 7000, clk cycles per SCL quarter-period
- CBITS, 15, width of the quarter counter; must satisfy 2^CBITS > DIVIDER

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-requester request, held until its gnt
- req_addr  in  NREQ*7  7-bit slave address per requester, slice i = [7i+6:7i]
- req_rw  in  NREQ  1 = read, 0 = write
- req_wdata  in  NREQ*8  write byte per requester
- gnt  out  NREQ  one-hot, one-cycle pulse on acceptance
- busy  out  1  transaction in progress
- done  out  1  one-cycle pulse at transaction end
- ack_err  out  1  slave NACKed the last transaction; valid with done, held until next gnt
- rdata  out  8  read byte; valid with done, held until next read completes
- scl_o, sda_o  out  1  open-drain controls: 0 = pull low, 1 = release
- scl_i, sda_i  in  1  sensed bus levels

## Operation
- Reset values: scl_o=1, sda_o=1, gnt=0, busy=0, done=0, ack_err=0, rdata=0, round-robin pointer=0, state IDLE, quarter counter 0.
- Arbitration (IDLE only): grant the first asserted req at or after pointer, wrapping. On grant: latch addr/rw/wdata, pulse gnt, set busy, pointer = granted index + 1 (mod NREQ). req is ignored while busy.
- States: IDLE -> START -> ADDR (8 bits: addr[6:0] MSB first, then rw) -> AACK -> DATA (8 bits) -> DACK -> STOP -> IDLE.
- AACK samples sda_i = 1 (NACK): set ack_err, skip DATA/DACK, go to STOP.
- Write: DATA drives wdata MSB first; DACK samples sda_i, 1 sets ack_err. Read: DATA releases SDA and shifts sda_i into rdata; DACK drives sda_o=1 (master NACK).
- Bit slot = quarters q0..q3. Data bits: SCL low in q0–q1, high in q2–q3; SDA updated on entry to q0 and held for the slot; sda_i sampled on the cycle entering q3.
- START slot: SCL high all quarters; SDA high in q0–q1, low in q2–q3.
- STOP slot: SDA low all of q0–q2, high in q3; SCL low in q0–q1, high in q2–q3.
- Stretching: whenever scl_o=1 and scl_i=0, the quarter counter freezes; counting resumes on the first cycle scl_i=1. Applies in every state.
- Reset mid-transaction: abort at once, release both lines, no STOP generated, busy=0, no done pulse.

## Timing
- req high at cycle t in IDLE -> gnt and busy high in cycle t+1; START q0 begins at t+1.
- Quarter = DIVIDER cycles; slot = 4*DIVIDER cycles plus stretch cycles.
- Full transaction: 20 slots; ACKed path has done in the cycle after STOP q3 ends, i.e. gnt + 80*DIVIDER (+ stretch); busy falls with done.
- NACKed address: 11 slots, done at gnt + 44*DIVIDER.
- Next grant earliest the cycle after done.
- Quarter counter wraps DIVIDER-1 -> 0 and advances the quarter; q3 wrap advances the bit/state.

## Structure
- Package i2c_seq_pkg: state enum (IDLE, START, ADDR, AACK, DATA, DACK, STOP), quarter enum (Q0..Q3), constants ADDR_BITS=7, DATA_BITS=8.
- Sub-module i2c_quarter_gen: counter 0..DIVIDER-1 with stall and clear inputs; outputs quarter index and end-of-quarter strobe. Top holds arbiter, FSM, shift registers.

## Test plan
Bench uses DIVIDER=4 and a behavioural slave model.
- Write req[0], addr 0x50, rw 0, wdata 0xA5, slave ACKs -> gnt=4'b0001; SDA bits 1010000,0 then 10100101; done at gnt+320; ack_err=0.
- Same request with sda_i held 1 -> ack_err=1, no data slots, done at gnt+176.
- Read addr 0x21, slave returns 0x3C -> rdata=0x3C, sda_o=1 during DACK, ack_err=0.
- req=4'b1011 held continuously -> grant order 0,1,3,0.
- Slave holds scl_i low 10 cycles in q2 of address bit 3 -> done delayed by exactly 10 cycles.
- rst during DATA bit 4 -> next cycle scl_o=sda_o=1, busy=0, no done; next grant goes to req[0].
